// File: rtl/cmult_scheduler_4_pkg.sv
// Shared definitions for the 4-point FFT complex-multiplier scheduler.
// Holds the default widths, the FSM state type and the multiplier completion test.
package cmult_scheduler_4_pkg;

    localparam int FFT4_DATA_W = 12;
    localparam int FFT4_PROD_W = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] MUL_ALL_RDY = 4'hF;

    // All four Booth multipliers must report ready; partial flags do not count.
    function automatic logic mul_done(input logic [3:0] rdy);
        return rdy == MUL_ALL_RDY;
    endfunction

endpackage

// File: rtl/cmult_scheduler_4_arb.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping from N_REQ-1 back to 0.
module rr_arbiter_4
    import cmult_scheduler_4_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gnt_idx,
    output logic                     any
);

    localparam int IDX_W = $clog2(N_REQ);

    always_comb begin
        int unsigned idx;
        logic [IDX_W-1:0] sel;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % 32'(N_REQ);
            sel = IDX_W'(idx);
            if (!any && req[sel]) begin
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cmult_scheduler_4.sv
// Shares one complex_multiplier_4 between N_REQ requesters: round-robin grant,
// one operation in flight, result returned tagged with the requester id.
module cmult_scheduler_4
    import cmult_scheduler_4_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = FFT4_DATA_W,
    parameter int PROD_W   = FFT4_PROD_W,
    parameter int MIN_LAT  = 2,
    parameter int MAX_WAIT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*DATA_W-1:0]   req_a,
    input  logic [N_REQ*DATA_W-1:0]   req_b,
    input  logic [N_REQ*DATA_W-1:0]   req_c,
    input  logic [N_REQ*DATA_W-1:0]   req_d,
    output logic                      mul_en,
    output logic [DATA_W-1:0]         mul_a,
    output logic [DATA_W-1:0]         mul_b,
    output logic [DATA_W-1:0]         mul_c,
    output logic [DATA_W-1:0]         mul_d,
    input  logic [3:0]                mul_rdy,
    input  logic [PROD_W-1:0]         mul_real,
    input  logic [PROD_W-1:0]         mul_img,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [$clog2(N_REQ)-1:0]  rsp_id,
    output logic [PROD_W-1:0]         rsp_real,
    output logic [PROD_W-1:0]         rsp_img,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_WAIT);

    state_t              state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                mul_en_q;
    logic [DATA_W-1:0]   mul_a_q, mul_b_q, mul_c_q, mul_d_q;
    logic                rsp_valid_q;
    logic [IDX_W-1:0]    rsp_id_q;
    logic [PROD_W-1:0]   rsp_real_q, rsp_img_q;
    logic                rsp_err_q;
    logic                timeout_err_q;

    logic [N_REQ-1:0]    arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic [IDX_W-1:0]    rr_ptr_d;
    logic [DATA_W-1:0]   sel_a, sel_b, sel_c, sel_d;
    logic                sampled_done;

    rr_arbiter_4 #(.N_REQ(N_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_c = '0;
        sel_d = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
                sel_c = req_c[i*DATA_W +: DATA_W];
                sel_d = req_d[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rr_ptr_d     = (arb_idx == IDX_W'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
    // Flags still high from the previous operation are masked for MIN_LAT cycles.
    assign sampled_done = (wait_cnt_q >= CNT_W'(MIN_LAT)) && mul_done(mul_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            wait_cnt_q    <= '0;
            mul_en_q      <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            mul_c_q       <= '0;
            mul_d_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= '0;
            rsp_real_q    <= '0;
            rsp_img_q     <= '0;
            rsp_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_any) begin
                        mul_a_q  <= sel_a;
                        mul_b_q  <= sel_b;
                        mul_c_q  <= sel_c;
                        mul_d_q  <= sel_d;
                        rsp_id_q <= arb_idx;
                        rr_ptr_q <= rr_ptr_d;
                        mul_en_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_en_q   <= 1'b0;
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                    if (sampled_done) begin
                        rsp_real_q  <= mul_real;
                        rsp_img_q   <= mul_img;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (wait_cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        rsp_real_q    <= '0;
                        rsp_img_q     <= '0;
                        rsp_err_q     <= 1'b1;
                        timeout_err_q <= 1'b1;
                        rsp_valid_q   <= 1'b1;
                        state_q       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Grant is combinational so the requester sees it in the same IDLE cycle.
    assign req_ready   = (state_q == S_IDLE && !rst) ? arb_gnt : '0;
    assign mul_en      = mul_en_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_c       = mul_c_q;
    assign mul_d       = mul_d_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_real    = rsp_real_q;
    assign rsp_img     = rsp_img_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = timeout_err_q;

endmodule
